// File: rtl/trace_capture_pkg.sv
// Shared definitions for the instruction trace capture block: CPU state
// encodings, the packed trace entry layout and a saturating counter helper.
package trace_capture_pkg;

  localparam logic [3:0] FETCH_STATE_DEF  = 4'd0;
  localparam logic [3:0] DECODE_STATE_DEF = 4'd1;

  localparam int SEQ_W   = 16;
  localparam int PC_W    = 32;
  localparam int IR_W    = 32;
  localparam int TRACE_W = SEQ_W + PC_W + IR_W;

  // Field order fixes the bit offsets: seq [79:64], pc [63:32], ir [31:0].
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [PC_W-1:0]  pc;
    logic [IR_W-1:0]  ir;
  } trace_entry_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Valid/ready drain port carrying the head trace entry to a consumer.
interface trace_capture_if;
  import trace_capture_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [SEQ_W-1:0] out_seq;
  logic [PC_W-1:0]  out_pc;
  logic [IR_W-1:0]  out_ir;

  modport master (output out_valid, out_seq, out_pc, out_ir, input out_ready);
  modport slave  (input out_valid, out_seq, out_pc, out_ir, output out_ready);

endinterface

// File: rtl/trace_capture_fifo.sv
// Synchronous FIFO for trace entries; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 80
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which words are valid, and rdata is forced to zero when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/trace_capture.sv
// Watches the multi-cycle CPU debug outputs, records one {seq, pc, ir} entry
// per instruction entering decode, and flags PC breakpoints and dropped entries.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int         DEPTH        = 16,
  parameter logic [3:0] FETCH_STATE  = FETCH_STATE_DEF,
  parameter logic [3:0] DECODE_STATE = DECODE_STATE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PC_W-1:0]        cpu_pc,
  input  logic [IR_W-1:0]        cpu_ir,
  input  logic [3:0]             cpu_state,
  input  logic                   bp_en,
  input  logic [PC_W-1:0]        bp_addr,
  trace_capture_if.master        trace,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic                   bp_hit
);

  logic [3:0]       prev_state;
  logic [PC_W-1:0]  fetch_pc;
  logic [SEQ_W-1:0] seq;

  logic         retire;
  logic         pop;
  logic         push;
  logic         drop;
  logic         full;
  logic         empty;
  trace_entry_t wr_entry;
  trace_entry_t head;

  // A retire is the first cycle of decode; en gates only entry creation, so
  // raising en part-way through a long decode does not produce an entry.
  assign retire = en && (cpu_state == DECODE_STATE) && (prev_state != DECODE_STATE);
  assign pop    = !empty && trace.out_ready;
  assign push   = retire && (!full || pop);
  assign drop   = retire && full && !pop;

  assign wr_entry = '{seq: seq, pc: fetch_pc, ir: cpu_ir};

  trace_fifo #(.DEPTH(DEPTH), .W(TRACE_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_state <= FETCH_STATE;
      fetch_pc   <= '0;
      seq        <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      bp_hit     <= 1'b0;
    end else begin
      prev_state <= cpu_state;
      if (cpu_state == FETCH_STATE) fetch_pc <= cpu_pc;
      // seq advances even on a drop so the consumer can see the gap.
      if (retire) seq <= seq + 16'd1;
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc8(drop_cnt);
      end
      bp_hit <= retire && bp_en && (fetch_pc == bp_addr);
    end
  end

  assign trace.out_valid = !empty;
  assign trace.out_seq   = head.seq;
  assign trace.out_pc    = head.pc;
  assign trace.out_ir    = head.ir;

endmodule
